// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier controller and its datapath.
package booth_pkg;

  // Datapath command codes; the datapath acts only when the code changes.
  localparam logic [1:0] DP_INIT  = 2'b00;
  localparam logic [1:0] DP_ADD   = 2'b01;
  localparam logic [1:0] DP_SUB   = 2'b10;
  localparam logic [1:0] DP_SHIFT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ADD,
    S_SUB,
    S_CAN1,
    S_CAN2,
    S_SHIFT,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_NOP,
    OP_ADD,
    OP_SUB
  } booth_op_e;

  // Radix-2 Booth recoding of {B0, q_m1}.
  function automatic booth_op_e booth_decode(input logic b0, input logic q_m1);
    booth_op_e op;
    case ({b0, q_m1})
      2'b10:   op = OP_SUB;
      2'b01:   op = OP_ADD;
      default: op = OP_NOP;
    endcase
    return op;
  endfunction

  // Command issued while in a state. CAN1/CAN2 reuse ADD/SUB so a no-op
  // step still produces code changes; IDLE/DONE keep the last code.
  function automatic logic [1:0] state_cmd(input state_e s, input logic [1:0] hold);
    logic [1:0] cmd;
    case (s)
      S_INIT:  cmd = DP_INIT;
      S_ADD:   cmd = DP_ADD;
      S_SUB:   cmd = DP_SUB;
      S_CAN1:  cmd = DP_ADD;
      S_CAN2:  cmd = DP_SUB;
      S_SHIFT: cmd = DP_SHIFT;
      default: cmd = hold;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/booth_ctrl.sv
// Booth multiplier controller: sequences INIT/ADD/SUB/SHIFT commands to an
// external datapath and captures the product with a valid/ready handshake.
module booth_ctrl
  import booth_pkg::*;
#(
  parameter int unsigned BIT_LEN = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [BIT_LEN-1:0]     a_in,
  input  logic [BIT_LEN-1:0]     b_in,
  output logic                   in_ready,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*BIT_LEN-1:0]   product,
  output logic                   err,
  output logic [1:0]             dp_state,
  output logic [BIT_LEN-1:0]     dp_in1,
  output logic [BIT_LEN-1:0]     dp_in2,
  input  logic [1:0]             dp_signal,
  input  logic [2*BIT_LEN-1:0]   dp_out
);

  localparam int unsigned CNT_W = $clog2(BIT_LEN + 1);

  state_e                 state_q, state_d;
  logic [1:0]             dp_state_q, dp_state_d;
  logic [BIT_LEN-1:0]     dp_in1_q, dp_in1_d;
  logic [BIT_LEN-1:0]     dp_in2_q, dp_in2_d;
  logic [2*BIT_LEN-1:0]   product_q, product_d;
  logic                   err_q, err_d;
  logic                   q_m1_q, q_m1_d;
  logic [CNT_W-1:0]       shift_cnt_q, shift_cnt_d;

  booth_op_e              op;
  logic                   last_shift;

  // State and datapath-command registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dp_state_q  <= DP_SHIFT;
      dp_in1_q    <= '0;
      dp_in2_q    <= '0;
      product_q   <= '0;
      err_q       <= 1'b0;
      q_m1_q      <= 1'b0;
      shift_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      dp_state_q  <= dp_state_d;
      dp_in1_q    <= dp_in1_d;
      dp_in2_q    <= dp_in2_d;
      product_q   <= product_d;
      err_q       <= err_d;
      q_m1_q      <= q_m1_d;
      shift_cnt_q <= shift_cnt_d;
    end
  end

  // Next-state decode, operand capture, shift counting and result capture.
  always_comb begin
    state_d     = state_q;
    dp_in1_d    = dp_in1_q;
    dp_in2_d    = dp_in2_q;
    product_d   = product_q;
    err_d       = err_q;
    q_m1_d      = q_m1_q;
    shift_cnt_d = shift_cnt_q;

    op         = booth_decode(dp_signal[1], q_m1_q);
    last_shift = (shift_cnt_q == CNT_W'(1));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_INIT;
          dp_in1_d    = a_in;
          dp_in2_d    = b_in;
          shift_cnt_d = CNT_W'(BIT_LEN);
          err_d       = 1'b0;
          q_m1_d      = 1'b0;
        end
      end
      S_INIT: begin
        state_d = (op == OP_SUB) ? S_SUB : S_SHIFT;
      end
      S_ADD, S_SUB, S_CAN2: begin
        state_d = S_SHIFT;
      end
      S_CAN1: begin
        state_d = S_CAN2;
      end
      S_SHIFT: begin
        shift_cnt_d = shift_cnt_q - CNT_W'(1);
        if (dp_signal[0] != last_shift) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (last_shift) begin
          state_d = S_DONE;
        end else begin
          case (op)
            OP_SUB:  state_d = S_SUB;
            OP_ADD:  state_d = S_ADD;
            default: state_d = S_CAN1;
          endcase
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // SHIFT never follows itself, so state_d alone marks entry; B0 seen now
    // is the pre-shift LSB that becomes the Booth history bit.
    if (state_d == S_SHIFT) q_m1_d = dp_signal[1];

    if ((state_d == S_DONE) && (state_q != S_DONE)) product_d = dp_out;

    dp_state_d = state_cmd(state_d, dp_state_q);
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign product   = product_q;
  assign err       = err_q;
  assign dp_state  = dp_state_q;
  assign dp_in1    = dp_in1_q;
  assign dp_in2    = dp_in2_q;

endmodule

// File: tb/tb_booth_ctrl.sv
// Directed bench for booth_ctrl with a behavioural change-triggered datapath.
module tb_booth_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] a_in = '0;
  logic [3:0] b_in = '0;
  logic       in_ready, busy, out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] product;
  logic       err;
  logic [1:0] dp_state;
  logic [3:0] dp_in1, dp_in2;
  logic [1:0] dp_signal;
  logic [7:0] dp_out;

  int ncmp = 0;
  int nfail = 0;

  logic [1:0] trace [0:31];
  int         trace_n;
  bit         force_fin = 1'b0;

  always #5 clk = ~clk;

  booth_ctrl #(.BIT_LEN(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .in_ready(in_ready), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .product(product), .err(err),
    .dp_state(dp_state), .dp_in1(dp_in1), .dp_in2(dp_in2),
    .dp_signal(dp_signal), .dp_out(dp_out)
  );

  // Datapath model: a new command code shows its result combinationally and
  // commits at the next edge. X carries a guard bit.
  logic [4:0] m_x, n_x;
  logic [3:0] m_b, n_b, m_a, n_a;
  logic [3:0] m_cnt, n_cnt;
  logic [1:0] m_prev;

  always_comb begin
    n_x = m_x; n_b = m_b; n_a = m_a; n_cnt = m_cnt;
    if (dp_state != m_prev) begin
      case (dp_state)
        2'b00: begin n_x = '0; n_b = dp_in2; n_a = dp_in1; n_cnt = '0; end
        2'b01: n_x = m_x + {m_a[3], m_a};
        2'b10: n_x = m_x - {m_a[3], m_a};
        default: begin
          {n_x, n_b} = {m_x[4], m_x, m_b[3:1]};
          n_cnt = m_cnt + 4'd1;
        end
      endcase
    end
  end

  assign dp_signal = {n_b[0], force_fin ? 1'b1 : (n_cnt == 4'd4)};
  assign dp_out    = {n_x[3:0], n_b};

  always @(posedge clk) begin
    if (rst) begin
      m_prev <= 2'b11; m_x <= '0; m_b <= '0; m_a <= '0; m_cnt <= '0;
    end else begin
      m_prev <= dp_state; m_x <= n_x; m_b <= n_b; m_a <= n_a; m_cnt <= n_cnt;
    end
  end

  // Issue one multiply and wait (bounded) for out_valid; lat counts edges
  // from the accepting edge up to and including the one raising out_valid.
  task automatic do_mult(input logic [3:0] a, input logic [3:0] b, input bit noise,
                         output logic [7:0] p, output logic e, output int lat, output bit to);
    @(negedge clk);
    a_in = a; b_in = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1; trace_n = 0; to = 1'b0;
    while (out_valid !== 1'b1 && !to) begin
      if (trace_n < 32) begin trace[trace_n] = dp_state; trace_n++; end
      if (noise) begin start = 1'b1; a_in = 4'h7; b_in = 4'h7; end
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (lat > 60) to = 1'b1;
    end
    p = product; e = err;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    if ({in_ready, busy, out_valid} !== 3'b100) begin
      $display("FAIL reset_flags got %b want 100", {in_ready, busy, out_valid}); nfail++;
    end
    ncmp++;
    if (dp_state !== 2'b11) begin $display("FAIL reset_dp_state got %b want 11", dp_state); nfail++; end
    ncmp++;
    if ({dp_in1, dp_in2} !== 8'h00) begin $display("FAIL reset_dp_in got %h want 00", {dp_in1, dp_in2}); nfail++; end
    ncmp++;
    if ({product, err} !== 9'h000) begin $display("FAIL reset_product_err got %h want 000", {product, err}); nfail++; end
    ncmp++;
    rst = 1'b0;
    @(negedge clk);
    if (in_ready !== 1'b1) begin $display("FAIL post_reset_in_ready got %b want 1", in_ready); nfail++; end
    ncmp++;
  endtask

  task automatic test_basic();
    logic [7:0] p; logic e; int lat; bit to;
    logic [1:0] exp_tr [0:8];
    exp_tr = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11, 2'b01, 2'b11};
    do_mult(4'd3, 4'd5, 1'b0, p, e, lat, to);
    if (to !== 1'b0) begin $display("FAIL basic_timeout got %b want 0", to); nfail++; end
    ncmp++;
    if (p !== 8'h0F) begin $display("FAIL basic_product got %h want 0f", p); nfail++; end
    ncmp++;
    if (e !== 1'b0) begin $display("FAIL basic_err got %b want 0", e); nfail++; end
    ncmp++;
    if (lat !== 10) begin $display("FAIL basic_latency got %0d want 10", lat); nfail++; end
    ncmp++;
    if (trace_n !== 9) begin $display("FAIL basic_trace_len got %0d want 9", trace_n); nfail++; end
    ncmp++;
    for (int i = 0; i < 9; i++) begin
      if (trace[i] !== exp_tr[i]) begin
        $display("FAIL basic_trace[%0d] got %b want %b", i, trace[i], exp_tr[i]); nfail++;
      end
      ncmp++;
    end
    release_result();
    if (in_ready !== 1'b1) begin $display("FAIL basic_return_idle got %b want 1", in_ready); nfail++; end
    ncmp++;
  endtask

  task automatic test_signed();
    logic [7:0] p; logic e; int lat; bit to;
    do_mult(4'hD, 4'd5, 1'b0, p, e, lat, to);
    if (p !== 8'hF1) begin $display("FAIL signed_m3x5 got %h want f1", p); nfail++; end
    ncmp++;
    release_result();
    do_mult(4'd7, 4'h8, 1'b0, p, e, lat, to);
    if (p !== 8'hC8) begin $display("FAIL signed_7xm8 got %h want c8", p); nfail++; end
    ncmp++;
    if (to !== 1'b0) begin $display("FAIL signed_timeout got %b want 0", to); nfail++; end
    ncmp++;
    release_result();
  endtask

  task automatic test_zero();
    logic [7:0] p; logic e; int lat; bit to;
    logic [1:0] exp_tr [0:10];
    exp_tr = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11};
    do_mult(4'd0, 4'd0, 1'b0, p, e, lat, to);
    if (p !== 8'h00) begin $display("FAIL zero_product got %h want 00", p); nfail++; end
    ncmp++;
    if (lat !== 12) begin $display("FAIL zero_latency got %0d want 12", lat); nfail++; end
    ncmp++;
    if (trace_n !== 11) begin $display("FAIL zero_trace_len got %0d want 11", trace_n); nfail++; end
    ncmp++;
    for (int i = 0; i < 11; i++) begin
      if (trace[i] !== exp_tr[i]) begin
        $display("FAIL zero_trace[%0d] got %b want %b", i, trace[i], exp_tr[i]); nfail++;
      end
      ncmp++;
    end
    release_result();
  endtask

  task automatic test_backpressure();
    logic [7:0] p; logic e; int lat; bit to;
    do_mult(4'd2, 4'd3, 1'b1, p, e, lat, to);
    if (p !== 8'h06) begin $display("FAIL bp_product got %h want 06", p); nfail++; end
    ncmp++;
    if ({dp_in1, dp_in2} !== 8'h23) begin $display("FAIL bp_operands got %h want 23", {dp_in1, dp_in2}); nfail++; end
    ncmp++;
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; a_in = 4'h7; b_in = 4'h7;
      @(negedge clk);
      if ({out_valid, in_ready, product} !== {2'b10, 8'h06}) begin
        $display("FAIL bp_hold[%0d] got v=%b r=%b p=%h want v=1 r=0 p=06", i, out_valid, in_ready, product); nfail++;
      end
      ncmp++;
    end
    start = 1'b0;
    release_result();
    if ({in_ready, busy, out_valid} !== 3'b100) begin
      $display("FAIL bp_release got %b want 100", {in_ready, busy, out_valid}); nfail++;
    end
    ncmp++;
  endtask

  task automatic test_reset_midop();
    logic [7:0] p; logic e; int lat; bit to;
    int ns = 0;
    int guard = 0;
    @(negedge clk);
    a_in = 4'd3; b_in = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (ns < 2 && guard < 40) begin
      if (dp_state == 2'b11) ns++;
      if (ns < 2) @(negedge clk);
      guard++;
    end
    if (ns !== 2) begin $display("FAIL midop_reach_shift2 got %0d want 2", ns); nfail++; end
    ncmp++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if ({in_ready, busy, out_valid, dp_state, dp_in1, dp_in2, product, err} !== {3'b100, 2'b11, 17'h0}) begin
      $display("FAIL midop_reset got r=%b b=%b v=%b dp=%b in=%h p=%h e=%b want r=1 b=0 v=0 dp=11 in=00 p=00 e=0",
               in_ready, busy, out_valid, dp_state, {dp_in1, dp_in2}, product, err); nfail++;
    end
    ncmp++;
    do_mult(4'd2, 4'd3, 1'b0, p, e, lat, to);
    if (p !== 8'h06) begin $display("FAIL midop_after_product got %h want 06", p); nfail++; end
    ncmp++;
    release_result();
  endtask

  task automatic test_err();
    logic [7:0] p; logic e; int lat; bit to;
    force_fin = 1'b1;
    do_mult(4'd3, 4'd5, 1'b0, p, e, lat, to);
    force_fin = 1'b0;
    if (e !== 1'b1) begin $display("FAIL err_flag got %b want 1", e); nfail++; end
    ncmp++;
    if (lat !== 4) begin $display("FAIL err_latency got %0d want 4", lat); nfail++; end
    ncmp++;
    if (p !== 8'hEA) begin $display("FAIL err_product got %h want ea", p); nfail++; end
    ncmp++;
    release_result();
    do_mult(4'd3, 4'd5, 1'b0, p, e, lat, to);
    if ({e, p} !== 9'h00F) begin $display("FAIL err_cleared got e=%b p=%h want e=0 p=0f", e, p); nfail++; end
    ncmp++;
    release_result();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_zero();
    test_backpressure();
    test_reset_midop();
    test_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
